// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // An all-zero word terminates the program and parks the fetcher.
    localparam logic [31:0] INST_HALT = 32'h0;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush and occupancy count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  fetch_entry_t                   push_entry,
    input  logic                           pop,
    output fetch_entry_t                   head,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [QUEUE_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Depth is a power of two, so the pointers wrap modulo QUEUE_DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues single-word imem reads, queues responses, and hands them to decode.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_csb0,
    output logic                  imem_web0,
    output logic [ADDR_WIDTH-1:0] imem_addr0,
    output logic [31:0]           imem_din0,
    input  logic [31:0]           imem_dout0,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [31:0]           inst_pc
);

    localparam int             CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = QUEUE_DEPTH[CW:0];

    fetch_state_t   state_q, state_d;
    logic [31:0]    fetch_pc_q;
    logic [31:0]    tag_pc_q;
    logic           inflight_q;
    logic [CW-1:0]  q_count;
    logic [CW:0]    occupancy;
    fetch_entry_t   q_head;
    logic           issue, capture, push, pop;

    // Reserve a slot for the in-flight response so the queue can never overflow.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
    assign issue     = (state_q == FETCH) && !rst && !redirect_valid && (occupancy < DEPTH_W);
    assign capture   = inflight_q && (state_q == FETCH) && !rst && !redirect_valid;
    assign push      = capture && (imem_dout0 != INST_HALT);

    assign inst_valid = (q_count != '0) && !rst && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? q_head.inst : 32'h0;
    assign inst_pc    = inst_valid ? q_head.pc   : 32'h0;

    assign imem_csb0  = ~issue;
    assign imem_web0  = 1'b1;
    assign imem_din0  = 32'h0;
    assign imem_addr0 = fetch_pc_q[ADDR_WIDTH+1:2];

    // NOTE: default first so every path assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (redirect_valid)
            state_d = FETCH;
        else if (capture && (imem_dout0 == INST_HALT))
            state_d = HALT;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= 32'h0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
            end else if (issue) begin
                tag_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry ('{pc: tag_pc_q, inst: imem_dout0}),
        .pop        (pop),
        .head       (q_head),
        .count      (q_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch with a one-cycle-latency imem model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_csb0;
    logic        imem_web0;
    logic [7:0]  imem_addr0;
    logic [31:0] imem_din0;
    logic [31:0] imem_dout0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    localparam logic [31:0] PROG [5] = '{32'h003100b3, 32'h40730233, 32'h029301b3,
                                         32'h003103b3, 32'h00610433};
    localparam logic [31:0] W255 = 32'h00a00093;

    logic [31:0] imem [256];
    int          n_checks;
    int          n_fail;
    int          issue_cnt;
    int          n_got;
    int          first_valid;
    logic [31:0] got_pc   [16];
    logic [31:0] got_data [16];
    logic        tr_csb   [64];
    logic [7:0]  tr_addr  [64];

    inst_fetch #(
        .ADDR_WIDTH  (8),
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_csb0      (imem_csb0),
        .imem_web0      (imem_web0),
        .imem_addr0     (imem_addr0),
        .imem_din0      (imem_din0),
        .imem_dout0     (imem_dout0),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!imem_csb0) imem_dout0 <= imem[imem_addr0];
    end

    always @(posedge clk) begin
        if (!rst && !imem_csb0) issue_cnt <= issue_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    // Hold reset two cycles, release; returns at cycle 1 after release, inputs drivable.
    task automatic start(input logic ready);
        rst = 1'b1; redirect_valid = 1'b0; inst_ready = ready;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Observe max_cycles cycles, recording accepted transfers and imem requests per cycle.
    task automatic collect(input int max_cycles);
        n_got = 0; first_valid = 0;
        for (int c = 1; c <= max_cycles; c++) begin
            #1;
            tr_csb[c]  = imem_csb0;
            tr_addr[c] = imem_addr0;
            if (inst_valid && first_valid == 0) first_valid = c;
            if (inst_valid && inst_ready && n_got < 16) begin
                got_pc[n_got]   = inst_pc;
                got_data[n_got] = inst_data;
                n_got++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        #1;
        n_checks++; if (imem_csb0 !== 1'b1) begin n_fail++; $display("FAIL reset_csb0: got %b want 1", imem_csb0); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", inst_data); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        n_checks++; if (imem_web0 !== 1'b1 || imem_din0 !== 32'h0) begin
            n_fail++; $display("FAIL reset_ties: web0 %b din0 %h want 1/0", imem_web0, imem_din0);
        end
    endtask

    task automatic test_cold_start;
        start(1'b1);
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (c == 1) begin
                n_checks++; if (imem_csb0 !== 1'b0 || imem_addr0 !== 8'h00) begin
                    n_fail++; $display("FAIL cold_first_req: csb0 %b addr %h want 0/00", imem_csb0, imem_addr0);
                end
            end
            if (c < 3) begin
                n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL cold_latency c%0d: valid %b want 0", c, inst_valid); end
            end else if (c <= 7) begin
                n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'((c - 3) * 4) || inst_data !== PROG[c-3]) begin
                    n_fail++; $display("FAIL cold_stream c%0d: valid %b pc %h data %h want 1 %h %h",
                                       c, inst_valid, inst_pc, inst_data, 32'((c - 3) * 4), PROG[c-3]);
                end
            end else begin
                n_checks++; if (inst_valid !== 1'b0 || imem_csb0 !== 1'b1) begin
                    n_fail++; $display("FAIL cold_halt c%0d: valid %b csb0 %b want 0/1", c, inst_valid, imem_csb0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int base;
        start(1'b0);
        base = issue_cnt;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (c >= 6) begin
                n_checks++; if (imem_csb0 !== 1'b1) begin n_fail++; $display("FAIL bp_stall c%0d: csb0 %b want 1", c, imem_csb0); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (issue_cnt - base !== 4) begin n_fail++; $display("FAIL bp_issue_count: got %0d want 4", issue_cnt - base); end
        inst_ready = 1'b1;
        collect(20);
        n_checks++; if (n_got !== 5) begin n_fail++; $display("FAIL bp_total: got %0d transfers want 5", n_got); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got_pc[i] !== 32'(i * 4) || got_data[i] !== PROG[i]) begin
                n_fail++; $display("FAIL bp_order %0d: pc %h data %h want %h %h", i, got_pc[i], got_data[i], 32'(i * 4), PROG[i]);
            end
        end
    endtask

    task automatic test_redirect_inflight;
        start(1'b0);
        repeat (3) begin @(posedge clk); #1; end
        redirect_valid = 1'b1; redirect_pc = 32'h8; inst_ready = 1'b1;
        #1;
        n_checks++; if (inst_valid !== 1'b0 || imem_csb0 !== 1'b1) begin
            n_fail++; $display("FAIL redir_cycle: valid %b csb0 %b want 0/1", inst_valid, imem_csb0);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        collect(15);
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL redir_latency: got %0d want 3", first_valid); end
        n_checks++; if (n_got !== 3) begin n_fail++; $display("FAIL redir_total: got %0d want 3", n_got); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_pc[i] !== 32'(8 + i * 4) || got_data[i] !== PROG[2+i]) begin
                n_fail++; $display("FAIL redir_order %0d: pc %h data %h want %h %h", i, got_pc[i], got_data[i], 32'(8 + i * 4), PROG[2+i]);
            end
        end
    endtask

    task automatic test_halt_recovery;
        #1;
        n_checks++; if (imem_csb0 !== 1'b1 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_idle: csb0 %b valid %b want 1/0", imem_csb0, inst_valid);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        collect(15);
        n_checks++; if (n_got !== 4) begin n_fail++; $display("FAIL halt_total: got %0d want 4", n_got); end
        n_checks++; if (got_pc[0] !== 32'h4 || got_data[0] !== PROG[1]) begin
            n_fail++; $display("FAIL halt_first: pc %h data %h want 00000004 %h", got_pc[0], got_data[0], PROG[1]);
        end
        n_checks++; if (got_pc[3] !== 32'h10 || got_data[3] !== PROG[4]) begin
            n_fail++; $display("FAIL halt_last: pc %h data %h want 00000010 %h", got_pc[3], got_data[3], PROG[4]);
        end
    endtask

    task automatic test_reset_mid;
        start(1'b0);
        repeat (4) begin @(posedge clk); #1; end
        #1;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_pre: valid %b pc %h want 1 00000000", inst_valid, inst_pc);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (inst_valid !== 1'b0 || imem_csb0 !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_hold: valid %b csb0 %b want 0/1", inst_valid, imem_csb0);
        end
        @(posedge clk); #1;
        rst = 1'b0; inst_ready = 1'b1;
        collect(15);
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 3", first_valid); end
        n_checks++; if (n_got !== 5) begin n_fail++; $display("FAIL rstmid_total: got %0d want 5", n_got); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got_pc[i] !== 32'(i * 4) || got_data[i] !== PROG[i]) begin
                n_fail++; $display("FAIL rstmid_order %0d: pc %h data %h want %h %h", i, got_pc[i], got_data[i], 32'(i * 4), PROG[i]);
            end
        end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1; redirect_pc = 32'h3FC; inst_ready = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        collect(20);
        n_checks++; if (tr_csb[1] !== 1'b0 || tr_addr[1] !== 8'hFF) begin
            n_fail++; $display("FAIL wrap_addr_ff: csb0 %b addr %h want 0/ff", tr_csb[1], tr_addr[1]);
        end
        n_checks++; if (tr_csb[2] !== 1'b0 || tr_addr[2] !== 8'h00) begin
            n_fail++; $display("FAIL wrap_addr_00: csb0 %b addr %h want 0/00", tr_csb[2], tr_addr[2]);
        end
        n_checks++; if (got_pc[0] !== 32'h3FC || got_data[0] !== W255) begin
            n_fail++; $display("FAIL wrap_pc_3fc: pc %h data %h want 000003fc %h", got_pc[0], got_data[0], W255);
        end
        n_checks++; if (got_pc[1] !== 32'h400 || got_data[1] !== PROG[0]) begin
            n_fail++; $display("FAIL wrap_pc_400: pc %h data %h want 00000400 %h", got_pc[1], got_data[1], PROG[0]);
        end
        n_checks++; if (n_got !== 6 || got_pc[5] !== 32'h410) begin
            n_fail++; $display("FAIL wrap_tail: count %0d last pc %h want 6 00000410", n_got, got_pc[5]);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; issue_cnt = 0;
        imem_dout0 = 32'h0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        for (int i = 0; i < 5; i++) imem[i] = PROG[i];
        imem[255] = W255;

        test_reset;
        test_cold_start;
        test_backpressure;
        test_redirect_inflight;
        test_halt_recovery;
        test_reset_mid;
        test_wrap;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the imem word-address width.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning the number of fetch-queue entries (power of 2, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning the byte PC loaded at reset.
REQ-004 SHALL have port clk  in  1: the single clock; all state updates on its posedge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port imem_csb0  out  1: imem chip select, active low.
REQ-007 SHALL have port imem_web0  out  1: imem write enable, active low; tied 1.
REQ-008 SHALL have port imem_addr0  out  ADDR_WIDTH: imem word address.
REQ-009 SHALL have port imem_din0  out  32: imem write data; tied 0.
REQ-010 SHALL have port imem_dout0  in  32: imem read data, valid in the cycle after the request.
REQ-011 SHALL have port redirect_valid  in  1: a one-cycle request to flush and refetch.
REQ-012 SHALL have port redirect_pc  in  32: the target byte PC, sampled when redirect_valid=1.
REQ-013 SHALL have port inst_valid  out  1: the queue head is valid.
REQ-014 SHALL have port inst_ready  in  1: decode accepts; a transfer occurs when inst_valid and inst_ready are both 1.
REQ-015 SHALL have port inst_data  out  32: the queue-head instruction.
REQ-016 SHALL have port inst_pc  out  32: the queue-head byte PC.

Function
REQ-017 SHALL define imem_addr0 as fetch_pc[ADDR_WIDTH+1:2], driven combinationally from registers.
REQ-018 SHALL assert imem_csb0=0 in cycle N only when all of the following hold: state=FETCH, rst=0, redirect_valid=0, and count+inflight < QUEUE_DEPTH. Same-cycle dequeue is not credited.
REQ-019 SHALL, on an issue, set inflight=1 and tag_pc=fetch_pc, and advance fetch_pc by 4 (mod 2^32) at the same posedge; otherwise inflight clears at that posedge.
REQ-020 SHALL, with inflight=1, capture imem_dout0 and tag_pc at the posedge ending cycle N+1. Fetch latency is 2 cycles from issue to inst_valid.
REQ-021 SHALL enqueue a captured nonzero word together with tag_pc.
REQ-022 SHALL NOT enqueue a captured 32'h0 word; instead state goes to HALT and fetching stops.
REQ-023 SHALL keep FSM states FETCH and HALT. HALT->FETCH occurs only on redirect_valid=1.
REQ-024 SHALL, on redirect_valid=1, at that posedge: empty the queue, discard any inflight response (it is not enqueued), set fetch_pc=redirect_pc, and set state=FETCH. No issue occurs in the redirect cycle.
REQ-025 SHALL force inst_valid=0 while redirect_valid=1, so no transfer happens in the redirect cycle.
REQ-026 SHALL let redirect take priority over a simultaneous zero-word capture (state=FETCH) and over an enqueue.
REQ-027 SHALL support simultaneous enqueue and dequeue: count is unchanged and pointers wrap modulo QUEUE_DEPTH.
REQ-028 SHALL never overflow the queue (guaranteed by REQ-018) and never underflow it (inst_valid=0 when count=0).
REQ-029 SHALL let imem_addr0 wrap naturally: fetch_pc 0x3FC -> 0x400 gives addr0 0xFF -> 0x00 for ADDR_WIDTH=8.
REQ-030 SHALL sustain 1 instruction/cycle when inst_ready is held at 1.

Reset
REQ-031 SHALL, while rst=1, set fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, and state=FETCH.
REQ-032 SHALL hold these outputs during reset: imem_csb0=1, inst_valid=0, inst_data=0, inst_pc=0.
REQ-033 SHALL take priority for rst over redirect_valid. Reset mid-fetch discards the inflight response.

Structure
REQ-034 SHALL place in shared package fetch_pkg: the fetch_state_t enum {FETCH, HALT}, the fetch_entry_t struct {pc[31:0], inst[31:0]}, and the constant INST_HALT = 32'h0.
REQ-035 SHALL implement the queue as sub-module fetch_queue: a synchronous FIFO with a flush input and count output, parameterised by QUEUE_DEPTH.

Verification
REQ-036 SHALL cover cold start: imem holds 0x003100b3, 0x40730233, 0x029301b3, 0x003103b3, 0x00610433 at words 0..4 and 0 at word 5; release rst with inst_ready=1. Required: inst_valid rises in the 3rd cycle after release, the 5 instructions arrive on consecutive cycles with inst_pc 0x0..0x10, then HALT with csb0 held 1.
REQ-037 SHALL cover backpressure: hold inst_ready=0 for 10 cycles after start. Required: exactly QUEUE_DEPTH=4 entries are fetched, csb0 stays 1, and releasing inst_ready delivers pc 0x0,0x4,0x8,0xC then 0x10 in order with no loss or duplication.
REQ-038 SHALL cover redirect with an inflight request: assert redirect_valid with redirect_pc=0x8 while the queue holds 2 entries and a request is inflight. Required: the next delivered instruction is 0x029301b3 @ pc 0x8, and no stale entry appears.
REQ-039 SHALL cover HALT recovery: after the HALT at word 5, redirect to 0x4. Required: 0x40730233 @ 0x4 is delivered and fetching resumes.
REQ-040 SHALL cover reset mid-operation: assert rst for 1 cycle with 3 entries queued. Required: inst_valid=0 the next cycle and the sequence restarts from pc 0x0.
REQ-041 SHALL cover wrap-around: redirect to 0x3FC with words 255 and 0 nonzero. Required: imem_addr0 goes 0xFF then 0x00, and inst_pc goes 0x3FC then 0x400.
